// File: rtl/anc_sample_ingress.sv
// anc_sample_ingress
//
// Input stage for the ANC datapath. Each front-end strobe delivers one (x, e, a) sample
// triple, which goes into a small synchronous FIFO. The FIFO presents the head sample to
// the ANC top level under a valid/ready handshake. This rides out controller busy periods
// without losing samples. A sample that arrives while the FIFO is full and nothing pops is
// dropped, and the drop is recorded in a sticky flag.
//
// Optional feature (compile-time macro ANC_INGRESS_EGAIN_EN):
//   When defined, the stored e is s_e <<< e_shift, saturated to the 16-bit signed range.
//   When undefined, s_e is stored as-is and e_shift is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     front-end strobe; s_ready is advisory (FIFO not full)
//   s_x, s_e, s_a       incoming signed samples
//   e_shift             e gain shift (only with ANC_INGRESS_EGAIN_EN)
//   flush               synchronous empty; has priority over push and pop
//   m_valid/m_ready     head-sample handshake towards the controller
//   m_x, m_e, m_a       head sample, zero when m_valid is low
//   level               occupancy, 0..DEPTH
//   overflow, ovf_clr   sticky dropped-sample flag and its clear
module anc_sample_ingress #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   s_x,
    input  logic [15:0]   s_e,
    input  logic [15:0]   s_a,
    input  logic [1:0]    e_shift,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [15:0]   m_x,
    output logic [15:0]   m_e,
    output logic [15:0]   m_a,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [47:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [15:0]   e_store;
    logic [47:0]   head;

    assign full = (level_q == FULL_LEVEL);
    assign pop  = (level_q != '0) && m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = s_valid && !flush && (!full || pop);
    assign drop = s_valid && !flush && full && !pop;

`ifdef ANC_INGRESS_EGAIN_EN
    logic [18:0] e_wide;

    always_comb begin
        e_wide = {{3{s_e[15]}}, s_e} << e_shift;
        // The value fits in 16 bits only if the top four bits all agree in sign.
        if (e_wide[18:15] == 4'b0000 || e_wide[18:15] == 4'b1111) begin
            e_store = e_wide[15:0];
        end else if (e_wide[18]) begin
            e_store = 16'h8000;
        end else begin
            e_store = 16'h7FFF;
        end
    end
`else
    logic unused_e_shift;
    assign unused_e_shift = ^e_shift;
    assign e_store        = s_e;
`endif

    // Storage is not reset; level_q gates everything visible at the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= {s_x, e_store, s_a};
        end
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop) begin
                rp_d = rp_q + AW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign head     = mem_q[rp_q];
    assign m_valid  = (level_q != '0);
    assign m_x      = m_valid ? head[47:32] : '0;
    assign m_e      = m_valid ? head[31:16] : '0;
    assign m_a      = m_valid ? head[15:0]  : '0;
    assign s_ready  = !full;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule
